// File: rtl/pc_next_unit_if.sv
// Fetch-loop bundle between the PC/decoder side (master) and the next-address unit (slave).
interface pc_next_unit_if #(
   parameter int AW = 8,
   parameter int DW = 3
);
   logic [AW-1:0] pc_current;
   logic [2:0]    op;
   logic          cond;
   logic [AW-1:0] offset;
   logic [AW-1:0] target;
   logic          stall;
   logic [AW-1:0] pc_next;
   logic          halted;
   logic          fault;
   logic          overflow;
   logic          underflow;
   logic [DW-1:0] depth;

   modport master (
      output pc_current, op, cond, offset, target, stall,
      input  pc_next, halted, fault, overflow, underflow, depth
   );

   modport slave (
      input  pc_current, op, cond, offset, target, stall,
      output pc_next, halted, fault, overflow, underflow, depth
   );
endinterface

// File: rtl/pc_next_unit.sv
// Next-PC generator with return-address stack and RUN/HALT/FAULT control.
// pc_next is zero-latency from inputs; stall freezes everything and holds the PC.
module pc_next_unit #(
   parameter int AW    = 8,
   parameter int DEPTH = 4,
   parameter int DW    = 3
) (
   input logic           clock,
   input logic           reset_n,
   pc_next_unit_if.slave bus
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [2:0] OP_SEQ  = 3'd0;
   localparam logic [2:0] OP_BRZ  = 3'd1;
   localparam logic [2:0] OP_JMP  = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
   localparam logic [2:0] OP_RET  = 3'd4;
   localparam logic [2:0] OP_HALT = 3'd5;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_stack [DEPTH];
   logic [DW-1:0] r_depth;
   logic          r_ovf;
   logic          r_unf;

   logic [AW-1:0] w_seq;
   logic [AW-1:0] w_brz;
   logic [AW-1:0] w_top;
   logic [AW-1:0] w_pc_next;
   logic [IW-1:0] w_push_idx;
   logic [IW-1:0] w_top_idx;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_set_ovf;
   logic          w_set_unf;

   assign w_seq      = bus.pc_current + AW'(1);
   assign w_brz      = w_seq + bus.offset;
   assign w_full     = (r_depth == DW'(DEPTH));
   assign w_empty    = (r_depth == '0);
   assign w_push_idx = IW'(r_depth);
   assign w_top_idx  = IW'(r_depth - DW'(1));
   assign w_top      = r_stack[w_top_idx];

   // Default holds the PC: covers stall, HALT, FAULT and both stack faults.
   always_comb begin
      w_pc_next   = bus.pc_current;
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_set_ovf   = 1'b0;
      w_set_unf   = 1'b0;
      if (r_state == ST_RUN && !bus.stall) begin
         case (bus.op)
            OP_SEQ:  w_pc_next = w_seq;
            OP_BRZ:  w_pc_next = bus.cond ? w_brz : w_seq;
            OP_JMP:  w_pc_next = bus.target;
            OP_CALL: begin
               if (!w_full) begin
                  w_pc_next = bus.target;
                  w_push    = 1'b1;
               end else begin
                  w_state_nxt = ST_FAULT;
                  w_set_ovf   = 1'b1;
               end
            end
            OP_RET: begin
               if (!w_empty) begin
                  w_pc_next = w_top;
                  w_pop     = 1'b1;
               end else begin
                  w_state_nxt = ST_FAULT;
                  w_set_unf   = 1'b1;
               end
            end
            OP_HALT: w_state_nxt = ST_HALT;
            default: w_pc_next = w_seq;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= ST_RUN;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
         r_depth <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         if (w_push) begin
            r_stack[w_push_idx] <= w_seq;
            r_depth             <= r_depth + DW'(1);
         end else if (w_pop) begin
            r_depth <= r_depth - DW'(1);
         end
         if (w_set_ovf) r_ovf <= 1'b1;
         if (w_set_unf) r_unf <= 1'b1;
      end
   end

   assign bus.pc_next   = reset_n ? w_pc_next : '0;
   assign bus.halted    = (r_state == ST_HALT);
   assign bus.fault     = (r_state == ST_FAULT);
   assign bus.overflow  = r_ovf;
   assign bus.underflow = r_unf;
   assign bus.depth     = r_depth;
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: hand-computed next-PC, stack and status expectations.
module tb_pc_next_unit;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   pc_next_unit_if #(.AW(8), .DW(3)) bus ();

   pc_next_unit #(.AW(8), .DEPTH(4), .DW(3)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one request and let combinational pc_next settle.
   task automatic drive(input logic [7:0] pc, input logic [2:0] o, input logic c,
                        input logic [7:0] off, input logic [7:0] tgt, input logic st);
      bus.pc_current = pc;
      bus.op         = o;
      bus.cond       = c;
      bus.offset     = off;
      bus.target     = tgt;
      bus.stall      = st;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      tick();
      reset_n = 1'b1;
      #1;
   endtask

   initial begin
      drive(8'h12, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0);
      chk("rst_pc_next", 32'(bus.pc_next), 32'h00);
      chk("rst_depth", 32'(bus.depth), 0);
      chk("rst_halted", 32'(bus.halted), 0);
      chk("rst_fault", 32'(bus.fault), 0);
      chk("rst_ovf", 32'(bus.overflow), 0);
      chk("rst_unf", 32'(bus.underflow), 0);
      tick();
      reset_n = 1'b1;
      #1;

      // Sequential, wrap, reserved op, branches
      drive(8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0);
      chk("seq_00", 32'(bus.pc_next), 32'h01);
      drive(8'hFF, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0);
      chk("seq_wrap", 32'(bus.pc_next), 32'h00);
      drive(8'h30, 3'd6, 1'b1, 8'h00, 8'h77, 1'b0);
      chk("reserved6", 32'(bus.pc_next), 32'h31);
      drive(8'h30, 3'd7, 1'b1, 8'h00, 8'h77, 1'b0);
      chk("reserved7", 32'(bus.pc_next), 32'h31);
      drive(8'h10, 3'd1, 1'b1, 8'hFC, 8'h00, 1'b0);
      chk("brz_taken_neg", 32'(bus.pc_next), 32'h0D);
      drive(8'h10, 3'd1, 1'b0, 8'hFC, 8'h00, 1'b0);
      chk("brz_not_taken", 32'(bus.pc_next), 32'h11);
      drive(8'hFE, 3'd1, 1'b1, 8'h05, 8'h00, 1'b0);
      chk("brz_wrap", 32'(bus.pc_next), 32'h04);
      drive(8'h20, 3'd2, 1'b0, 8'h00, 8'h99, 1'b0);
      chk("jmp", 32'(bus.pc_next), 32'h99);
      tick();
      chk("jmp_depth", 32'(bus.depth), 0);

      // Call / return nesting
      drive(8'h05, 3'd3, 1'b0, 8'h00, 8'h40, 1'b0);
      chk("call1_pc", 32'(bus.pc_next), 32'h40);
      tick();
      chk("call1_depth", 32'(bus.depth), 1);
      drive(8'h42, 3'd3, 1'b0, 8'h00, 8'h80, 1'b0);
      chk("call2_pc", 32'(bus.pc_next), 32'h80);
      tick();
      chk("call2_depth", 32'(bus.depth), 2);
      drive(8'h80, 3'd4, 1'b0, 8'h00, 8'h00, 1'b0);
      chk("ret1_pc", 32'(bus.pc_next), 32'h43);
      tick();
      chk("ret1_depth", 32'(bus.depth), 1);
      drive(8'h44, 3'd4, 1'b0, 8'h00, 8'h00, 1'b0);
      chk("ret2_pc", 32'(bus.pc_next), 32'h06);
      tick();
      chk("ret2_depth", 32'(bus.depth), 0);

      // Stall has priority over CALL
      drive(8'h50, 3'd3, 1'b0, 8'h00, 8'h60, 1'b1);
      chk("stall_pc", 32'(bus.pc_next), 32'h50);
      tick();
      chk("stall_depth", 32'(bus.depth), 0);
      chk("stall_fault", 32'(bus.fault), 0);

      // Overflow
      for (int i = 0; i < 4; i++) begin
         drive(8'h10 + 8'(i), 3'd3, 1'b0, 8'h00, 8'h30, 1'b0);
         tick();
      end
      chk("full_depth", 32'(bus.depth), 4);
      drive(8'h20, 3'd3, 1'b0, 8'h00, 8'h70, 1'b0);
      chk("ovf_pc", 32'(bus.pc_next), 32'h20);
      chk("ovf_fault_pre", 32'(bus.fault), 0);
      tick();
      chk("ovf_fault", 32'(bus.fault), 1);
      chk("ovf_flag", 32'(bus.overflow), 1);
      chk("ovf_depth", 32'(bus.depth), 4);
      drive(8'h21, 3'd2, 1'b0, 8'h00, 8'h99, 1'b0);
      chk("fault_jmp_pc", 32'(bus.pc_next), 32'h21);
      drive(8'h21, 3'd4, 1'b0, 8'h00, 8'h00, 1'b0);
      chk("fault_ret_pc", 32'(bus.pc_next), 32'h21);
      tick();
      chk("fault_sticky", 32'(bus.fault), 1);
      chk("fault_depth_frozen", 32'(bus.depth), 4);

      // Async reset clears fault immediately
      reset_n = 1'b0;
      #1;
      chk("arst_fault", 32'(bus.fault), 0);
      chk("arst_ovf", 32'(bus.overflow), 0);
      chk("arst_depth", 32'(bus.depth), 0);
      chk("arst_pc_next", 32'(bus.pc_next), 32'h00);
      tick();
      reset_n = 1'b1;
      #1;

      // Underflow
      drive(8'h33, 3'd4, 1'b0, 8'h00, 8'h00, 1'b0);
      chk("unf_pc", 32'(bus.pc_next), 32'h33);
      tick();
      chk("unf_fault", 32'(bus.fault), 1);
      chk("unf_flag", 32'(bus.underflow), 1);
      chk("unf_ovf_clear", 32'(bus.overflow), 0);
      chk("unf_depth", 32'(bus.depth), 0);
      do_reset();

      // HALT is absorbing
      drive(8'h07, 3'd5, 1'b0, 8'h00, 8'h00, 1'b0);
      chk("halt_pc", 32'(bus.pc_next), 32'h07);
      tick();
      chk("halted", 32'(bus.halted), 1);
      chk("halt_no_fault", 32'(bus.fault), 0);
      drive(8'h08, 3'd3, 1'b0, 8'h00, 8'h40, 1'b0);
      chk("halt_call_pc", 32'(bus.pc_next), 32'h08);
      tick();
      chk("halt_call_depth", 32'(bus.depth), 0);
      drive(8'h09, 3'd2, 1'b0, 8'h00, 8'h99, 1'b0);
      chk("halt_jmp_pc", 32'(bus.pc_next), 32'h09);
      tick();
      chk("halt_sticky", 32'(bus.halted), 1);
      do_reset();
      chk("halt_cleared", 32'(bus.halted), 0);

      // Reset mid-cycle at depth 3, with a CALL held in flight
      for (int i = 0; i < 3; i++) begin
         drive(8'h60 + 8'(i), 3'd3, 1'b0, 8'h00, 8'hA0, 1'b0);
         tick();
      end
      chk("d3_depth", 32'(bus.depth), 3);
      drive(8'hA5, 3'd3, 1'b0, 8'h00, 8'hC0, 1'b0);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_depth", 32'(bus.depth), 0);
      chk("mid_rst_pc_next", 32'(bus.pc_next), 32'h00);
      chk("mid_rst_unf", 32'(bus.underflow), 0);
      tick();
      chk("rst_hold_depth", 32'(bus.depth), 0);
      reset_n = 1'b1;
      #1;
      chk("post_rst_pc", 32'(bus.pc_next), 32'hC0);
      tick();
      chk("post_rst_depth", 32'(bus.depth), 1);
      drive(8'hC0, 3'd4, 1'b0, 8'h00, 8'h00, 1'b0);
      chk("post_rst_ret", 32'(bus.pc_next), 32'hA6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Next-address generator that closes the fetch loop with the program counter.
- Takes the current PC value and the decoded control-flow request for the instruction at that address. Produces the address the PC loads on the next clock edge.
- Keeps a small return-address stack for CALL/RET and a RUN/HALT/FAULT state machine.
- Sits between the PC and the instruction decoder. pc_next drives the PC's address input.

Parameters:
- AW, 8: address width; must match the PC width.
- DEPTH, 4: return-address stack entries, 1..16.
- DW, 3: width of the depth output; must satisfy 2^DW > DEPTH.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc_current  in  AW  current PC value (PC output).
- op  in  3  control-flow request: 0 SEQ, 1 BRZ, 2 JMP, 3 CALL, 4 RET, 5 HALT, 6/7 reserved (treated as SEQ).
- cond  in  1  branch condition for BRZ (zero flag).
- offset  in  AW  signed two's-complement branch displacement.
- target  in  AW  absolute target for JMP/CALL.
- stall  in  1  hold PC; ignore op this cycle.
- pc_next  out  AW  address for the PC to load at the next edge (combinational).
- halted  out  1  state == HALT.
- fault  out  1  state == FAULT (sticky).
- overflow  out  1  sticky: CALL attempted with a full stack.
- underflow  out  1  sticky: RET attempted with an empty stack.
- depth  out  DW  number of valid stack entries.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=RUN, depth=0, all stack entries=0, overflow=0, underflow=0.
  - pc_next forced to 0 while reset_n is low.
- Definitions:
  - seq = pc_current+1.
  - All address arithmetic is modulo 2^AW (wraps: 8'hFF+1 = 8'h00).
  - BRZ target = pc_current + 1 + sign-extended offset, modulo 2^AW.
- pc_next in RUN with stall=0 (combinational, zero latency from inputs):
  - SEQ/reserved → seq.
  - BRZ → branch target if cond=1, else seq.
  - JMP → target.
  - CALL → target, if depth<DEPTH.
  - RET → stack[depth-1], if depth>0.
  - HALT → pc_current.
- Stack updates at the clock edge, RUN only, stall=0:
  - CALL with depth<DEPTH: stack[depth] ← seq; depth ← depth+1.
  - RET with depth>0: depth ← depth-1. Popped entry contents need not be cleared.
  - The stack is LIFO. Entries are indexed from 0; top = stack[depth-1].
- Fault conditions, RUN with stall=0:
  - CALL with depth==DEPTH: pc_next=pc_current; next state FAULT; overflow←1; stack unchanged.
  - RET with depth==0: pc_next=pc_current; next state FAULT; underflow←1.
- HALT op in RUN with stall=0: next state HALT.
- stall=1 in any state: pc_next=pc_current; no state, stack or flag change. Stall has priority over op.
- HALT state:
  - pc_next=pc_current for all ops.
  - Stack and flags frozen.
  - Exit only via reset.
- FAULT state:
  - Same freeze as HALT; fault=1.
  - Exit only via reset.
- Transitions:
  - RUN→HALT on HALT op.
  - RUN→FAULT on overflow/underflow.
  - HALT and FAULT are absorbing.
  - Any state→RUN on reset_n low.
- Outputs halted, fault, overflow, underflow and depth are registered. They change only at the clock edge or on asynchronous reset.
- Reset mid-operation:
  - An asserted reset_n overrides any in-flight CALL/RET; no push or pop completes.
  - The first edge after reset_n rises evaluates ops normally from depth=0.

Test Plan:
- Sequential and wrap: after reset, drive SEQ with pc_current 8'h00 → pc_next 8'h01. Drive pc_current 8'hFF → pc_next 8'h00.
- Branch:
  - pc=8'h10, BRZ, offset=8'hFC, cond=1 → pc_next 8'h0D.
  - Same with cond=0 → 8'h11.
  - pc=8'hFE, offset=8'h05, cond=1 → 8'h04.
- Call/return nesting:
  - CALL target 8'h40 at pc 8'h05 → pc_next 8'h40, depth 1.
  - CALL target 8'h80 at pc 8'h42 → depth 2.
  - RET → pc_next 8'h43, depth 1.
  - RET → 8'h06, depth 0.
- Overflow: 4 CALLs then a 5th CALL at pc 8'h20 → pc_next 8'h20; next edge fault=1, overflow=1, depth 4. A subsequent JMP 8'h99 → pc_next stays pc_current.
- Underflow and HALT:
  - RET at depth 0, pc 8'h33 → pc_next 8'h33; fault=1, underflow=1.
  - After reset, HALT at pc 8'h07 → halted=1; pc_next=pc_current thereafter, including for CALL/JMP.
- Stall and async reset:
  - stall=1 with CALL → pc_next=pc_current, depth unchanged.
  - Assert reset_n low mid-cycle at depth 3 → depth 0, pc_next 0 and flags 0 immediately, without waiting for a clock edge.
